// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble packer: default geometry, accumulator
// state encoding and the out_cnt width helper.
package nibble_pkg;

   localparam int NIB_W_DEF         = 4;
   localparam int NIBS_PER_WORD_DEF = 4;

   typedef enum logic [0:0] {
      ACC_EMPTY = 1'b0,
      ACC_PART  = 1'b1
   } acc_state_t;

   // Wide enough to hold the full count NIBS_PER_WORD, not just 0..N-1.
   function automatic int cnt_w(input int nibs_per_word);
      return $clog2(nibs_per_word) + 1;
   endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble-in / word-out handshake bundle for nibble_packer.
// out_par exists only when NIBBLE_PACKER_PARITY_EN is defined.
interface nibble_packer_if
   import nibble_pkg::*;
#(
   parameter int NIB_W         = NIB_W_DEF,
   parameter int NIBS_PER_WORD = NIBS_PER_WORD_DEF
);

   localparam int CW = cnt_w(NIBS_PER_WORD);
   localparam int DW = NIB_W * NIBS_PER_WORD;

   // Both sides: a beat transfers on a rising edge where valid && ready;
   // valid must not wait on ready, and payload is stable while valid && !ready.
   logic             in_valid;
   logic             in_ready;
   logic [NIB_W-1:0] in_d;
   logic             in_last;

   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [CW-1:0]    out_cnt;
   logic             out_last;
`ifdef NIBBLE_PACKER_PARITY_EN
   logic             out_par;

   modport slave (
      input  in_valid, in_d, in_last, out_ready,
      output in_ready, out_valid, out_data, out_cnt, out_last, out_par
   );

   modport master (
      output in_valid, in_d, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_cnt, out_last, out_par
   );
`else
   modport slave (
      input  in_valid, in_d, in_last, out_ready,
      output in_ready, out_valid, out_data, out_cnt, out_last
   );

   modport master (
      output in_valid, in_d, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_cnt, out_last
   );
`endif

endinterface

// File: rtl/nibble_packer_out_reg.sv
// Output word register: loads a closed word, holds it under back-pressure,
// drains on transfer. Parity bit present with NIBBLE_PACKER_PARITY_EN.
module nibble_out_reg
   import nibble_pkg::*;
#(
   parameter int DW = NIB_W_DEF * NIBS_PER_WORD_DEF,
   parameter int CW = cnt_w(NIBS_PER_WORD_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic [CW-1:0] load_cnt,
   input  logic          load_last,
`ifdef NIBBLE_PACKER_PARITY_EN
   input  logic          load_par,
   output logic          out_par,
`endif
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] out_cnt,
   output logic          out_last
);

   // load is only raised when the slot is free or draining this cycle, so a
   // held word is never overwritten; after a plain drain the payload holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
         out_last  <= 1'b0;
`ifdef NIBBLE_PACKER_PARITY_EN
         out_par   <= 1'b0;
`endif
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_cnt   <= load_cnt;
         out_last  <= load_last;
`ifdef NIBBLE_PACKER_PARITY_EN
         out_par   <= load_par;
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nibble_packer.sv
// Packs a valid/ready nibble stream into NIBS_PER_WORD-nibble words with an
// early close on in_last. Optional out_par via NIBBLE_PACKER_PARITY_EN.
module nibble_packer
   import nibble_pkg::*;
#(
   parameter int NIB_W         = NIB_W_DEF,
   parameter int NIBS_PER_WORD = NIBS_PER_WORD_DEF
) (
   input  logic            clk,
   input  logic            rst,
   nibble_packer_if.slave  bus,
   output acc_state_t      state
);

   localparam int CW = cnt_w(NIBS_PER_WORD);
   localparam int DW = NIB_W * NIBS_PER_WORD;

   logic [DW-1:0] acc_data;
   logic [CW-1:0] acc_cnt;
   logic [CW-1:0] next_cnt;
   logic [DW-1:0] word_data;
   logic          in_xfer;
   logic          close;

   // Stalls on any pending word, even one this nibble would not replace.
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign in_xfer      = bus.in_valid && bus.in_ready;
   assign next_cnt     = acc_cnt + CW'(1);
   assign close        = in_xfer && (bus.in_last || next_cnt == CW'(NIBS_PER_WORD));

   // Lanes above acc_cnt are already zero because the accumulator clears on close.
   always_comb begin
      word_data = acc_data;
      for (int i = 0; i < NIBS_PER_WORD; i++) begin
         if (CW'(i) == acc_cnt) begin
            word_data[i*NIB_W +: NIB_W] = bus.in_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ACC_EMPTY;
         acc_data <= '0;
         acc_cnt  <= '0;
      end else if (in_xfer) begin
         if (close) begin
            state    <= ACC_EMPTY;
            acc_data <= '0;
            acc_cnt  <= '0;
         end else begin
            state    <= ACC_PART;
            acc_data <= word_data;
            acc_cnt  <= next_cnt;
         end
      end
   end

`ifdef NIBBLE_PACKER_PARITY_EN
   logic word_par;
   assign word_par = ^word_data;
`endif

   nibble_out_reg #(
      .DW (DW),
      .CW (CW)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (close),
      .load_data (word_data),
      .load_cnt  (next_cnt),
      .load_last (bus.in_last),
`ifdef NIBBLE_PACKER_PARITY_EN
      .load_par  (word_par),
      .out_par   (bus.out_par),
`endif
      .out_ready (bus.out_ready),
      .out_valid (bus.out_valid),
      .out_data  (bus.out_data),
      .out_cnt   (bus.out_cnt),
      .out_last  (bus.out_last)
   );

endmodule
